// File: rtl/spi_cmd_regs.sv
// SPI command register block: decodes completed ESP-link messages into reset requests,
// keyboard matrix, hand-controller bytes and a keyboard FIFO. Optional: SPIREGS_STATUS_READBACK_EN.
module spi_cmd_regs #(
    parameter int unsigned KBBUF_DEPTH        = 16,
    parameter int unsigned NUM_HCTRL          = 2,
    parameter int unsigned RESET_PULSE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   spi_msg_end,
    input  logic [7:0]             spi_cmd,
    input  logic [63:0]            spi_rxdata,
    output logic [63:0]            spi_txdata,
    output logic                   spi_txdata_valid,
    output logic                   reset_req,
    output logic                   reset_req_cold,
    output logic [63:0]            keys,
    output logic [8*NUM_HCTRL-1:0] hctrl,
    output logic [15:0]            kbbuf_data,
    output logic                   kbbuf_valid,
    input  logic                   kbbuf_ready,
    output logic                   kbbuf_overflow
);

    localparam int unsigned PW = (KBBUF_DEPTH > 1) ? $clog2(KBBUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(KBBUF_DEPTH + 1);
    localparam int unsigned RW = $clog2(RESET_PULSE_CYCLES + 1);

    localparam logic [7:0] CMD_RESET      = 8'h01;
    localparam logic [7:0] CMD_SET_KEYB   = 8'h10;
    localparam logic [7:0] CMD_SET_HCTRL  = 8'h11;
    localparam logic [7:0] CMD_STATUS     = 8'h12;
    localparam logic [7:0] CMD_WRITE_KBUF = 8'h13;
    localparam logic [7:0] CMD_FLUSH_KBUF = 8'h14;

    localparam logic [RW-1:0] PULSE_LAST = RW'(RESET_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(KBBUF_DEPTH);

    // Command strobes, qualified by message completion
    logic cmd_reset_c;
    logic cmd_keyb_c;
    logic cmd_hctrl_c;
    logic cmd_push_c;
    logic cmd_flush_c;

    always_comb begin
        cmd_reset_c = spi_msg_end && (spi_cmd == CMD_RESET);
        cmd_keyb_c  = spi_msg_end && (spi_cmd == CMD_SET_KEYB);
        cmd_hctrl_c = spi_msg_end && (spi_cmd == CMD_SET_HCTRL);
        cmd_push_c  = spi_msg_end && (spi_cmd == CMD_WRITE_KBUF);
        cmd_flush_c = spi_msg_end && (spi_cmd == CMD_FLUSH_KBUF);
    end

    // Reset pulse: counter holds remaining cycles after the current one
    logic [RW-1:0] pulse_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_cnt      <= '0;
            reset_req      <= 1'b0;
            reset_req_cold <= 1'b0;
        end else if (cmd_reset_c) begin
            pulse_cnt      <= PULSE_LAST;
            reset_req      <= 1'b1;
            reset_req_cold <= spi_rxdata[57];
        end else if (pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - RW'(1);
        end else begin
            reset_req      <= 1'b0;
            reset_req_cold <= 1'b0;
        end
    end

    // Keyboard matrix and hand-controller registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keys  <= '1;
            hctrl <= '1;
        end else begin
            if (cmd_keyb_c) begin
                keys <= spi_rxdata;
            end
            if (cmd_hctrl_c) begin
                for (int unsigned n = 0; n < NUM_HCTRL; n++) begin
                    if (spi_rxdata[63:56] == 8'(n)) begin
                        hctrl[8*n +: 8] <= spi_rxdata[55:48];
                    end
                end
            end
        end
    end

    // Keyboard FIFO
    logic [15:0]   kbbuf_mem [KBBUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full_c;
    logic          pop_c;
    logic          push_ok_c;

    always_comb begin
        full_c    = (count == COUNT_FULL);
        pop_c     = kbbuf_valid && kbbuf_ready;
        push_ok_c = cmd_push_c && (!full_c || pop_c);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            kbbuf_overflow <= 1'b0;
        end else if (cmd_flush_c) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            kbbuf_overflow <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok_c && !pop_c) begin
                count <= count + CW'(1);
            end else if (pop_c && !push_ok_c) begin
                count <= count - CW'(1);
            end
            if (cmd_push_c && !push_ok_c) begin
                kbbuf_overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; only pointers qualify its contents
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            kbbuf_mem[wr_ptr] <= spi_rxdata[63:48];
        end
    end

    always_comb begin
        kbbuf_valid = (count != '0);
        kbbuf_data  = kbbuf_valid ? kbbuf_mem[rd_ptr] : 16'h0000;
    end

`ifdef SPIREGS_STATUS_READBACK_EN
    // Status readback is combinational on the current command byte
    always_comb begin
        spi_txdata       = '0;
        spi_txdata_valid = 1'b0;
        if (spi_cmd == CMD_STATUS) begin
            spi_txdata_valid = 1'b1;
            spi_txdata       = {8'(count), 7'b0, kbbuf_overflow, keys[47:0]};
        end
    end
`else
    logic unused_status_c;
    assign unused_status_c  = (spi_cmd == CMD_STATUS);
    assign spi_txdata       = '0;
    assign spi_txdata_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_regs.sv
// Directed self-checking bench for spi_cmd_regs with hand-computed expected values.
module tb_spi_cmd_regs;

    logic        clk;
    logic        reset_n;
    logic        spi_msg_end;
    logic [7:0]  spi_cmd;
    logic [63:0] spi_rxdata;
    logic [63:0] spi_txdata;
    logic        spi_txdata_valid;
    logic        reset_req;
    logic        reset_req_cold;
    logic [63:0] keys;
    logic [15:0] hctrl;
    logic [15:0] kbbuf_data;
    logic        kbbuf_valid;
    logic        kbbuf_ready;
    logic        kbbuf_overflow;

    int n_vec;
    int n_err;

    spi_cmd_regs #(
        .KBBUF_DEPTH       (16),
        .NUM_HCTRL         (2),
        .RESET_PULSE_CYCLES(4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .spi_msg_end     (spi_msg_end),
        .spi_cmd         (spi_cmd),
        .spi_rxdata      (spi_rxdata),
        .spi_txdata      (spi_txdata),
        .spi_txdata_valid(spi_txdata_valid),
        .reset_req       (reset_req),
        .reset_req_cold  (reset_req_cold),
        .keys            (keys),
        .hctrl           (hctrl),
        .kbbuf_data      (kbbuf_data),
        .kbbuf_valid     (kbbuf_valid),
        .kbbuf_ready     (kbbuf_ready),
        .kbbuf_overflow  (kbbuf_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one message at a negedge; returns at the next negedge with effects visible
    task automatic send(input logic [7:0] c, input logic [63:0] d);
        spi_cmd     = c;
        spi_rxdata  = d;
        spi_msg_end = 1'b1;
        @(negedge clk);
        spi_msg_end = 1'b0;
        spi_cmd     = 8'h00;
    endtask

    task automatic push(input logic [15:0] w);
        send(8'h13, {w, 48'h0});
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        spi_msg_end = 1'b0;
        spi_cmd     = 8'h00;
        spi_rxdata  = '0;
        kbbuf_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_keys",  keys, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_hctrl", 64'(hctrl), 64'hFFFF);
        check("rst_valid", 64'(kbbuf_valid), 64'h0);
        check("rst_data",  64'(kbbuf_data), 64'h0);
        check("rst_ovf",   64'(kbbuf_overflow), 64'h0);
        check("rst_req",   64'(reset_req), 64'h0);
        check("rst_cold",  64'(reset_req_cold), 64'h0);
        check("rst_txv",   64'(spi_txdata_valid), 64'h0);

        // Reset pulse, cold=1, exactly 4 cycles
        send(8'h01, 64'h0200_0000_0000_0000);
        for (int i = 1; i <= 6; i++) begin
            check($sformatf("pulse_req_%0d", i), 64'(reset_req), 64'(i <= 4));
            check($sformatf("pulse_cold_%0d", i), 64'(reset_req_cold), 64'(i <= 4));
            @(negedge clk);
        end

        // Retrigger at pulse cycle 2 with cold=0: 6 cycles total, cold reloaded
        send(8'h01, 64'h0200_0000_0000_0000);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("retrig_req_%0d", i), 64'(reset_req), 64'(i <= 6));
            check($sformatf("retrig_cold_%0d", i), 64'(reset_req_cold), 64'(i <= 2));
            if (i == 2) begin
                spi_cmd     = 8'h01;
                spi_rxdata  = 64'h0;
                spi_msg_end = 1'b1;
            end else begin
                spi_msg_end = 1'b0;
                spi_cmd     = 8'h00;
            end
            @(negedge clk);
        end

        // Keyboard matrix, hand controllers, unknown command
        send(8'h10, 64'h0123_4567_89AB_CDEF);
        check("keys_set", keys, 64'h0123_4567_89AB_CDEF);
        send(8'h11, 64'h01A5 << 48);
        check("hctrl_ch1", 64'(hctrl), 64'hA5FF);
        send(8'h11, 64'h0533 << 48);
        check("hctrl_badidx", 64'(hctrl), 64'hA5FF);
        send(8'h11, 64'h005A << 48);
        check("hctrl_ch0", 64'(hctrl), 64'hA55A);
        send(8'h55, 64'hDEAD_BEEF_0000_0000);
        check("unknown_keys", keys, 64'h0123_4567_89AB_CDEF);
        check("unknown_hctrl", 64'(hctrl), 64'hA55A);
        spi_cmd    = 8'h10;
        spi_rxdata = 64'h0;
        @(negedge clk);
        check("no_strobe_keys", keys, 64'h0123_4567_89AB_CDEF);
        spi_cmd = 8'h00;

        // Overflow: 17 pushes with consumer stalled
        push(16'h0001);
        check("fwft_valid", 64'(kbbuf_valid), 64'h1);
        check("fwft_data",  64'(kbbuf_data), 64'h0001);
        for (int i = 2; i <= 16; i++) push(16'(i));
        check("full_no_ovf", 64'(kbbuf_overflow), 64'h0);
        push(16'h0011);
        check("ovf_set", 64'(kbbuf_overflow), 64'h1);
        kbbuf_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain_%0d", i), 64'(kbbuf_data), 64'(i));
            @(negedge clk);
        end
        kbbuf_ready = 1'b0;
        check("drain_empty", 64'(kbbuf_valid), 64'h0);
        check("drain_data0", 64'(kbbuf_data), 64'h0);
        check("ovf_sticky",  64'(kbbuf_overflow), 64'h1);
        send(8'h14, 64'h0);
        check("flush_ovf", 64'(kbbuf_overflow), 64'h0);

        // Full FIFO, push together with a pop
        for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
        spi_cmd     = 8'h13;
        spi_rxdata  = {16'hBEEF, 48'h0};
        spi_msg_end = 1'b1;
        kbbuf_ready = 1'b1;
        @(negedge clk);
        spi_msg_end = 1'b0;
        spi_cmd     = 8'h00;
        kbbuf_ready = 1'b0;
        check("pushpop_ovf",  64'(kbbuf_overflow), 64'h0);
        check("pushpop_head", 64'(kbbuf_data), 64'h0101);
`ifdef SPIREGS_STATUS_READBACK_EN
        spi_cmd = 8'h12;
        #1;
        check("pushpop_count", 64'(spi_txdata[63:56]), 64'h10);
        @(negedge clk);
        spi_cmd = 8'h00;
`endif
        push(16'h7777);
        check("still_full", 64'(kbbuf_overflow), 64'h1);
        send(8'h14, 64'h0);
        check("flush_valid", 64'(kbbuf_valid), 64'h0);
        check("flush_ovf2",  64'(kbbuf_overflow), 64'h0);

        // Push-with-pop ordering on a full FIFO: BEEF last out
        for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
        spi_cmd     = 8'h13;
        spi_rxdata  = {16'hBEEF, 48'h0};
        spi_msg_end = 1'b1;
        kbbuf_ready = 1'b1;
        @(negedge clk);
        spi_msg_end = 1'b0;
        spi_cmd     = 8'h00;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("order_%0d", i), 64'(kbbuf_data),
                  (i < 15) ? 64'(16'h0101 + 16'(i)) : 64'hBEEF);
            @(negedge clk);
        end
        kbbuf_ready = 1'b0;
        check("order_empty", 64'(kbbuf_valid), 64'h0);

        // Flush wins over a simultaneous pop; pointers restart cleanly
        push(16'h00AA);
        push(16'h00BB);
        kbbuf_ready = 1'b1;
        send(8'h14, 64'h0);
        kbbuf_ready = 1'b0;
        check("flush_pop_valid", 64'(kbbuf_valid), 64'h0);
        push(16'h00CC);
        check("post_flush_head", 64'(kbbuf_data), 64'h00CC);
        send(8'h14, 64'h0);

        // Status readback
        push(16'h0011);
        push(16'h0022);
        push(16'h0033);
        spi_cmd = 8'h12;
        #1;
`ifdef SPIREGS_STATUS_READBACK_EN
        check("rb_valid", 64'(spi_txdata_valid), 64'h1);
        check("rb_data",  spi_txdata, 64'h0300_4567_89AB_CDEF);
`else
        check("rb_off_valid", 64'(spi_txdata_valid), 64'h0);
        check("rb_off_data",  spi_txdata, 64'h0);
`endif
        spi_cmd = 8'h10;
        #1;
        check("rb_other_valid", 64'(spi_txdata_valid), 64'h0);
        check("rb_other_data",  spi_txdata, 64'h0);
        @(negedge clk);
        send(8'h12, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rb_nofx_keys", keys, 64'h0123_4567_89AB_CDEF);
        check("rb_nofx_head", 64'(kbbuf_data), 64'h0011);
        check("rb_nofx_req",  64'(reset_req), 64'h0);
        kbbuf_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rb_nofx_third", 64'(kbbuf_data), 64'h0033);
        @(negedge clk);
        kbbuf_ready = 1'b0;
        check("rb_nofx_empty", 64'(kbbuf_valid), 64'h0);

        // Asynchronous reset mid-operation
        send(8'h01, 64'h0200_0000_0000_0000);
        push(16'h1234);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_req",   64'(reset_req), 64'h0);
        check("async_valid", 64'(kbbuf_valid), 64'h0);
        check("async_keys",  keys, 64'hFFFF_FFFF_FFFF_FFFF);
        check("async_hctrl", 64'(hctrl), 64'hFFFF);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
